adder_serial_nibble: RTL and testbench



---
 rtl/adder_serial_nibble_if.sv | 24 ++
 rtl/adder_serial_nibble.sv | 115 +++++++++++
 tb/tb_adder_serial_nibble.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/adder_serial_nibble_if.sv
// Handshake and data bundle between an adder_serial_nibble controller and its requester.
interface adder_serial_nibble_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   add;
    logic [4*NIBBLES-1:0]   aug;
    logic                   preC;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   sum;
    logic                   proC;
    logic                   ovf;

    modport master (
        output start, add, aug, preC,
        input  busy, done, sum, proC, ovf
    );

    modport slave (
        input  start, add, aug, preC,
        output busy, done, sum, proC, ovf
    );
endinterface

// File: rtl/adder_serial_nibble.sv
// Serial multi-nibble adder: one 4-bit adder reused LSB-first with a registered carry.
// Optional signed-overflow flag enabled by defining ADDER_SERIAL_OVF_EN.
module adder_full_4bit (
    input  logic [3:0] add,
    input  logic [3:0] aug,
    input  logic       preC,
    output logic [3:0] sum,
    output logic       proC
);
    assign {proC, sum} = {1'b0, add} + {1'b0, aug} + {4'b0000, preC};
endmodule

module adder_serial_nibble #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_serial_nibble_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     add_q;
    logic [W-1:0]     aug_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     sum_q;
    logic             proc_q;
    logic [3:0]       nib_sum;
    logic             nib_carry;
    logic             accept;
    logic             last;

    assign accept = (state != RUN) && bus.start;
    assign last   = (idx == IDX_W'(NIBBLES - 1));

    adder_full_4bit u_adder (
        .add  (add_q[4*idx +: 4]),
        .aug  (aug_q[4*idx +: 4]),
        .preC (carry_q),
        .sum  (nib_sum),
        .proC (nib_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and per-nibble result write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            add_q   <= '0;
            aug_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
            proc_q  <= 1'b0;
        end else if (accept) begin
            add_q   <= bus.add;
            aug_q   <= bus.aug;
            carry_q <= bus.preC;
            idx     <= '0;
            sum_q   <= '0;
            proc_q  <= 1'b0;
        end else if (state == RUN) begin
            sum_q[4*idx +: 4] <= nib_sum;
            carry_q           <= nib_carry;
            if (last) begin
                proc_q <= nib_carry;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef ADDER_SERIAL_OVF_EN
    logic ovf_q;

    // Carry into the sign bit recovered from the sign-bit sum: c = a ^ b ^ s
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= add_q[W-1] ^ aug_q[W-1] ^ nib_sum[3] ^ nib_carry;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.proC = proc_q;
endmodule

// File: tb/tb_adder_serial_nibble.sv
// Self-checking bench for adder_serial_nibble (NIBBLES=4): cycle scoreboard plus directed vectors.
module tb_adder_serial_nibble;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    adder_serial_nibble_if #(.NIBBLES(N)) bus();

    adder_serial_nibble #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef ADDER_SERIAL_OVF_EN
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: cycles-remaining view of the transaction, checked 1 time unit after each edge
    int         left = 0;
    logic       m_done = 1'b0;
    logic [W:0] m_res = '0;
    logic       m_ovf = 1'b0;
    logic [W:0] pend_res = '0;
    logic       pend_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            left = 0; m_done = 1'b0; m_res = '0; m_ovf = 1'b0;
        end else if (left == 0 && bus.start) begin
            left = N; m_done = 1'b0; m_res = '0; m_ovf = 1'b0;
            pend_res = {1'b0, bus.add} + {1'b0, bus.aug} + {{W{1'b0}}, bus.preC};
            pend_ovf = model_ovf(bus.add, bus.aug, bus.preC);
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_done = 1'b1; m_res = pend_res; m_ovf = pend_ovf;
            end
        end else begin
            m_done = 1'b0;
        end
        #1;
        chk("sb_busy", 32'(bus.busy), 32'(left > 0));
        chk("sb_done", 32'(bus.done), 32'(m_done));
        if (left == 0) begin
            chk("sb_sum", 32'(bus.sum), 32'(m_res[W-1:0]));
            chk("sb_proC", 32'(bus.proC), 32'(m_res[W]));
            chk("sb_ovf", 32'(bus.ovf), 32'(m_ovf));
        end
    end

    task automatic run_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W-1:0] exp_sum, input logic exp_c,
                           input logic exp_ovf);
        int lat;
        int busy_n;
        @(negedge clk);
        bus.add = a; bus.aug = b; bus.preC = c; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.add = ~a; bus.aug = ~b; bus.preC = ~c;
        lat = 0;
        busy_n = 0;
        while (!bus.done && lat < 20) begin
            busy_n += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(N));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(N));
        chk({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({name, "_proC"}, 32'(bus.proC), 32'(exp_c));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    endtask

    task automatic count_done(input string name, input int cycles, input int exp_n);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n += int'(bus.done);
        end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    logic ovf_on;

    initial begin
`ifdef ADDER_SERIAL_OVF_EN
        ovf_on = 1'b1;
`else
        ovf_on = 1'b0;
`endif
        bus.start = 1'b0; bus.add = '0; bus.aug = '0; bus.preC = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_sum", 32'(bus.sum), 32'd0);
        rst = 1'b0;

        run_add("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_add("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_add("allcarry", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_add("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, ovf_on);
        run_add("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, ovf_on);

        // start pulsed during RUN must not disturb the operation in flight
        @(negedge clk);
        bus.add = 16'h0001; bus.aug = 16'h0001; bus.preC = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.add = 16'h00FF; bus.aug = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10 && !bus.done; i++) @(negedge clk);
        chk("ignore_done", 32'(bus.done), 32'd1);
        chk("ignore_sum", 32'(bus.sum), 32'h0002);
        count_done("ignore_single_done", 8, 0);

        // reset mid-RUN abandons the operation
        @(negedge clk);
        bus.add = 16'hAAAA; bus.aug = 16'h5555; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_proC", 32'(bus.proC), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        count_done("abort_no_done", 8, 0);
        run_add("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // start held high: one result every N+1 cycles
        @(negedge clk);
        bus.add = 16'h0101; bus.aug = 16'h0202; bus.preC = 1'b0; bus.start = 1'b1;
        begin
            int last_done = -1;
            int pulses = 0;
            for (int i = 0; i < 3 * (N + 1) + 2; i++) begin
                @(negedge clk);
                if (bus.done) begin
                    chk("b2b_sum", 32'(bus.sum), 32'h0303);
                    if (last_done >= 0) chk("b2b_period", 32'(i - last_done), 32'(N + 1));
                    last_done = i;
                    pulses++;
                end
            end
            chk("b2b_pulses", 32'(pulses), 32'd3);
        end
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
